// File: rtl/score_text_pkg.sv
// Shared types, constants and the character-select helper for the
// "SCORE: TT" HUD text writer.
package score_text_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    FIN
  } state_t;

  localparam int STR_LEN   = 9;
  localparam int LABEL_LEN = 7;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_ZERO  = 7'h30;

  // Fixed "SCORE: " prefix, one entry per character position.
  localparam logic [6:0] LABEL [LABEL_LEN] = '{
    7'h53, 7'h43, 7'h4F, 7'h52, 7'h45, 7'h3A, 7'h20
  };

  // Map a string position to its character: label text first, then the
  // (optionally blanked) tens digit, then the ones digit.
  function automatic logic [6:0] char_sel(
    input logic [3:0] idx,
    input logic [6:0] tens,
    input logic [6:0] ones,
    input logic       blank_lead
  );
    logic [6:0] ch;
    ch = ones;
    if (idx < 4'(LABEL_LEN)) begin
      ch = LABEL[idx[2:0]];
    end else if (idx == 4'(LABEL_LEN)) begin
      ch = (blank_lead && (tens == ASCII_ZERO)) ? ASCII_SPACE : tens;
    end
    return ch;
  endfunction

endpackage

// File: rtl/score_text_writer.sv
// Writes the HUD string "SCORE: TT" into the character text buffer, one
// character per valid/ready handshake. The whole string is rewritten after
// reset and on every score update; updates arriving mid-string are
// coalesced into a single rewrite once the current string finishes.
module score_text_writer
  import score_text_pkg::*;
#(
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = 11,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            ascii_tens,
  input  logic [6:0]            ascii_ones,
  input  logic                  update,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [6:0]            wr_char,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0]            LAST_IDX = 4'(STR_LEN - 1);

  state_t                state, state_nx;
  logic [3:0]            index, index_nx;
  logic                  pending, pending_nx;
  logic [6:0]            tens_q, tens_nx;
  logic [6:0]            ones_q, ones_nx;
  logic                  wr_valid_nx;
  logic [ADDR_WIDTH-1:0] wr_addr_nx;
  logic [6:0]            wr_char_nx;
  logic                  busy_nx;
  logic                  done_nx;

  // State, latched digits and all outputs are registered; pending starts
  // set so the string is written once straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      pending  <= 1'b1;
      tens_q   <= ASCII_ZERO;
      ones_q   <= ASCII_ZERO;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_char  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      index    <= index_nx;
      pending  <= pending_nx;
      tens_q   <= tens_nx;
      ones_q   <= ones_nx;
      wr_valid <= wr_valid_nx;
      wr_addr  <= wr_addr_nx;
      wr_char  <= wr_char_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state and next-output logic; digits are latched only in IDLE so a
  // string is never built from two different scores.
  always_comb begin
    state_nx    = state;
    index_nx    = index;
    pending_nx  = pending;
    tens_nx     = tens_q;
    ones_nx     = ones_q;
    wr_valid_nx = wr_valid;
    wr_addr_nx  = wr_addr;
    wr_char_nx  = wr_char;
    busy_nx     = busy;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        busy_nx     = 1'b0;
        wr_valid_nx = 1'b0;
        if (pending || update) begin
          tens_nx    = ascii_tens;
          ones_nx    = ascii_ones;
          pending_nx = 1'b0;
          index_nx   = '0;
          busy_nx    = 1'b1;
          state_nx   = LOAD;
        end
      end

      LOAD: begin
        if (update) pending_nx = 1'b1;
        wr_addr_nx  = BASE + ADDR_WIDTH'(index);
        wr_char_nx  = char_sel(index, tens_q, ones_q, BLANK_LEAD != 0);
        wr_valid_nx = 1'b1;
        state_nx    = WRITE;
      end

      WRITE: begin
        if (update) pending_nx = 1'b1;
        if (wr_ready) begin
          wr_valid_nx = 1'b0;
          if (index == LAST_IDX) begin
            done_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            index_nx = index + 4'd1;
            state_nx = LOAD;
          end
        end
      end

      FIN: begin
        if (update) pending_nx = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        state_nx    = IDLE;
        busy_nx     = 1'b0;
        wr_valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_score_text_writer.sv
// Scoreboard bench for score_text_writer: stimulus pushes whole expected
// strings into a queue, a monitor pops one entry per accepted write.
module tb_score_text_writer;

  localparam int BASE_ADDR  = 2043;
  localparam int ADDR_WIDTH = 11;
  localparam int BLANK_LEAD = 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [6:0]            ch;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [6:0]            ascii_tens;
  logic [6:0]            ascii_ones;
  logic                  update;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [6:0]            wr_char;
  logic                  busy;
  logic                  done;

  exp_t exp_q[$];
  int   total;
  int   bad;
  logic rand_ready;
  logic ready_force;

  score_text_writer #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BLANK_LEAD(BLANK_LEAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ascii_tens(ascii_tens),
    .ascii_ones(ascii_ones),
    .update    (update),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .busy      (busy),
    .done      (done)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ready driver: random backpressure or a value forced by directed tests.
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: the full string as text, digits substituted at the end.
  task automatic push_string(input logic [6:0] tens, input logic [6:0] ones);
    string label;
    byte   b;
    exp_t  e;
    label = "SCORE: ";
    for (int i = 0; i < 9; i++) begin
      e.addr = ADDR_WIDTH'((BASE_ADDR + i) % (1 << ADDR_WIDTH));
      if (i < 7) begin
        b    = label[i];
        e.ch = b[6:0];
      end else if (i == 7) begin
        e.ch = (BLANK_LEAD != 0 && tens == "0") ? 7'h20 : tens;
      end else begin
        e.ch = ones;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int idle_cnt;
    idle_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      idle_cnt = busy ? 0 : idle_cnt + 1;
      if (idle_cnt >= 2) return;
    end
    check_output("wait_idle_timeout", 1, 0);
  endtask

  task automatic apply_stimulus(input logic [6:0] tens, input logic [6:0] ones);
    ascii_tens = tens;
    ascii_ones = ones;
    update     = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  // Monitor: scoreboard pop on acceptance, handshake stability, done spacing.
  initial begin
    logic                  prev_valid;
    logic                  prev_ready;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [6:0]            prev_char;
    int                    accepts;
    exp_t                  e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_addr  = '0;
    prev_char  = '0;
    accepts    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        accepts    = 0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check_output("hold_valid", int'(wr_valid), 1);
          check_output("hold_addr", int'(wr_addr), int'(prev_addr));
          check_output("hold_char", int'(wr_char), int'(prev_char));
        end
        if (done) begin
          check_output("done_after_9", accepts, 9);
          accepts = 0;
        end
        if (wr_valid && wr_ready) begin
          accepts++;
          if (exp_q.size() == 0) begin
            check_output("unexpected_write", int'(wr_addr), -1);
          end else begin
            e = exp_q.pop_front();
            check_output("wr_addr", int'(wr_addr), int'(e.addr));
            check_output("wr_char", int'(wr_char), int'(e.ch));
          end
        end
        prev_valid = wr_valid;
        prev_ready = wr_ready;
        prev_addr  = wr_addr;
        prev_char  = wr_char;
      end
    end
  end

  // Directed scenarios followed by randomized coalescing traffic.
  initial begin
    int n_upd;
    int kmax;
    int c;
    total       = 0;
    bad         = 0;
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    rst_n       = 1'b0;
    update      = 1'b0;
    ascii_tens  = 7'h30;
    ascii_ones  = 7'h30;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_valid", int'(wr_valid), 0);
    check_output("rst_addr", int'(wr_addr), 0);
    check_output("rst_char", int'(wr_char), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);

    // Release: the initial string "SCORE:  0" is written unprompted.
    push_string(7'h30, 7'h30);
    rst_n = 1'b1;
    wait_idle();

    // Latency with ready high, then update landing in the done cycle.
    apply_stimulus(7'h34, 7'h32);
    push_string(7'h34, 7'h32);
    check_output("lat_busy_n1", int'(busy), 1);
    check_output("lat_valid_n1", int'(wr_valid), 0);
    @(posedge clk);
    #1;
    check_output("lat_valid_n2", int'(wr_valid), 1);
    repeat (16) @(posedge clk);
    #1;
    check_output("lat_done_n18", int'(done), 0);
    @(posedge clk);
    #1;
    check_output("lat_done_n19", int'(done), 1);
    apply_stimulus(7'h37, 7'h31);
    push_string(7'h37, 7'h31);
    check_output("lat_done_n20", int'(done), 0);
    check_output("lat_busy_n20", int'(busy), 0);
    @(posedge clk);
    #1;
    check_output("rewrite_busy", int'(busy), 1);
    check_output("rewrite_valid_early", int'(wr_valid), 0);
    @(posedge clk);
    #1;
    check_output("rewrite_valid", int'(wr_valid), 1);
    wait_idle();

    // Backpressure at index 3 for 5 cycles.
    apply_stimulus(7'h39, 7'h38);
    push_string(7'h39, 7'h38);
    c = 0;
    while (exp_q.size() != 6 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    ready_force = 1'b0;
    repeat (7) @(posedge clk);
    ready_force = 1'b1;
    wait_idle();

    // Coalescing: "12" then "13","14" while busy gives exactly "12","14".
    apply_stimulus(7'h31, 7'h32);
    push_string(7'h31, 7'h32);
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(7'h31, 7'h33);
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(7'h31, 7'h34);
    push_string(7'h31, 7'h34);
    wait_idle();
    repeat (30) @(posedge clk);

    // Reset mid-string while index 5 is stalled.
    apply_stimulus(7'h35, 7'h36);
    push_string(7'h35, 7'h36);
    c = 0;
    while (exp_q.size() != 4 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    ready_force = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_valid", int'(wr_valid), 0);
    check_output("async_addr", int'(wr_addr), 0);
    check_output("async_char", int'(wr_char), 0);
    check_output("async_busy", int'(busy), 0);
    exp_q.delete();
    ascii_tens = 7'h30;
    ascii_ones = 7'h30;
    repeat (3) @(posedge clk);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    push_string(7'h30, 7'h30);
    rst_n = 1'b1;
    wait_idle();

    // Random digits, random backpressure, random extra updates while busy.
    rand_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      wait_idle();
      ascii_tens = 7'h30 + 7'($urandom_range(0, 9));
      ascii_ones = 7'h30 + 7'($urandom_range(0, 9));
      push_string(ascii_tens, ascii_ones);
      apply_stimulus(ascii_tens, ascii_ones);
      n_upd = 0;
      kmax  = $urandom_range(0, 3);
      for (int j = 0; j < kmax; j++) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        if (busy) begin
          apply_stimulus(7'h30 + 7'($urandom_range(0, 9)),
                         7'h30 + 7'($urandom_range(0, 9)));
          n_upd++;
        end
      end
      if (n_upd > 0) push_string(ascii_tens, ascii_ones);
    end
    wait_idle();
    repeat (40) @(posedge clk);
    check_output("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_text_writer.md
Name: score_text_writer

Overview:
- Takes the two ASCII digit characters produced by the binary-to-ASCII stage and writes the HUD string "SCORE: TT" into the character text buffer.
- The text buffer is the RAM read by the character-draw stage.
- Writes one character per accepted valid/ready handshake.
- Rewrites the whole string after reset and whenever the score changes. An update that arrives mid-write is coalesced.

Parameters:
- BASE_ADDR, 0, text-buffer address of the first character ('S').
- ADDR_WIDTH, 11, width of the text-buffer address bus.
- BLANK_LEAD, 1, when 1 a tens digit of '0' is written as ASCII space (7'h20).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ascii_tens  in  7  ASCII tens digit, 7'h30..7'h39.
- ascii_ones  in  7  ASCII ones digit, 7'h30..7'h39.
- update  in  1  single-cycle strobe: score digits changed, sampled this cycle.
- wr_valid  out  1  character write request.
- wr_ready  in  1  text buffer accepts the write this cycle.
- wr_addr  out  ADDR_WIDTH  text-buffer address.
- wr_char  out  7  ASCII character to write.
- busy  out  1  high while a string write is in progress.
- done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low; clock and reset ports are clk and rst_n.
- Reset values:
  - wr_valid=0, wr_addr=0, wr_char=0, busy=0, done=0.
  - Internal: index=0, pending=1, latched digits = 7'h30/7'h30.
  - Setting pending=1 at reset forces an initial "SCORE:  0" write after reset (with BLANK_LEAD=1).
- String, 9 characters:
  - Index 0..6: 'S','C','O','R','E',':',' ' (7'h53,43,4F,52,45,3A,20).
  - Index 7: latched tens. If BLANK_LEAD=1 and the latched tens is 7'h30, write 7'h20 instead.
  - Index 8: latched ones.
- Address: wr_addr = BASE_ADDR + index, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- State machine:
  - IDLE: busy=0, wr_valid=0. If pending or update: latch ascii_tens/ascii_ones, clear pending, index=0, go to LOAD.
  - LOAD: register wr_addr/wr_char for the current index, set wr_valid=1, go to WRITE. All outputs are registered.
  - WRITE: hold wr_valid, wr_addr and wr_char stable until wr_ready=1.
    - On acceptance with index<8: index+1, go to LOAD.
    - On acceptance with index==8: drop wr_valid, go to FIN.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in LOAD, WRITE and FIN.
- Latency with wr_ready tied high:
  - update at cycle N: first wr_valid at N+2.
  - One character every 2 cycles.
  - done at N+19, busy low from N+20.
- update while busy: set pending=1. The digits are not re-latched mid-string, so a string is never mixed. Several updates during busy collapse into one rewrite, which uses the digits present when IDLE re-latches (the cycle after FIN).
- update and FIN in the same cycle: pending=1, and the rewrite starts from IDLE on the next cycle.
- wr_ready is ignored while wr_valid=0. wr_valid is never deasserted before acceptance.
- Reset asserted mid-string: abort immediately to the reset values above. After release the full string is rewritten (pending=1).
- Digits outside 7'h30..7'h39 are passed through unchecked.

Decomposition:
- Package score_text_pkg:
  - state enum (IDLE, LOAD, WRITE, FIN);
  - STR_LEN=9;
  - the 7-character label constant array;
  - ASCII_SPACE and ASCII_ZERO constants.
- No sub-module: a character-select function in the package maps index plus latched digits to wr_char.

Test Plan:
- Reset release, wr_ready=1: writes to addresses 0..8 the characters 53,43,4F,52,45,3A,20,20,30. done pulses once at the 9th acceptance +1 cycle, busy then low.
- BASE_ADDR=100, update with tens=7'h34 and ones=7'h32: addresses 100..108, last two characters 34,32 ("42"). done exactly 19 cycles after update.
- wr_ready held low 5 cycles at index 3: wr_valid/wr_addr/wr_char stable all 5 cycles, index 4 issued only after the ready cycle.
- update("12") then update("13") and update("14") during busy: first string ends "12", then exactly one more string ending "14", with no third string.
- update in the same cycle as done: a second full string follows, starting 2 cycles later.
- rst_n low at index 5: outputs zero asynchronously. After release the full string from index 0 with digits "  0"; no partial write completes.
